// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ack handshake,
// one-entry hold buffer and the IF/ID pipeline register.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   stall               ID not ready; IF/ID holds
//   redirect_valid/_pc  next fetch address override (jump/branch)
//   imem_req/_addr      fetch request and address (= current_pc)
//   imem_rdata/_ack     instruction word and same-cycle response
//   current_pc          registered PC
//   if_id_*             IF/ID register contents
//
// Optional feature macro: IF_FETCH_PERF_CNT_EN
//   adds fetch_count (instructions written into IF/ID) and
//   wait_count (FETCH cycles without ack).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] current_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [25:0] if_id_instr_index
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic [31:0] r_if_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_instr;

    state_t      w_nstate;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_buf_pc_plus4;
    logic        w_ack;
    logic        w_clr_valid;
    logic        w_ld_fetch;
    logic        w_ld_hold;
    logic        w_buf_ld;
    logic        w_unused;

    // Target is word-aligned; the low bits are dropped on purpose.
    assign w_unused       = ^redirect_pc[1:0];

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_buf_pc_plus4 = r_buf_pc + 32'd4;

    // An ack only counts while a request is actually out.
    assign w_ack          = imem_ack && (r_state == S_FETCH);

    always_comb begin
        w_nstate    = r_state;
        w_pc_nxt    = r_pc;
        w_clr_valid = 1'b0;
        w_ld_fetch  = 1'b0;
        w_ld_hold   = 1'b0;
        w_buf_ld    = 1'b0;
        if (redirect_valid) begin
            // Wins over stall and ack; any fetched word is dropped.
            w_nstate    = S_FETCH;
            w_pc_nxt    = {redirect_pc[31:2], 2'b00};
            w_clr_valid = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nstate = S_FETCH;
                end
                S_FETCH: begin
                    if (w_ack && !stall) begin
                        w_ld_fetch = 1'b1;
                        w_pc_nxt   = w_pc_plus4;
                    end else if (w_ack && stall) begin
                        // Park the word so the request is not lost.
                        w_buf_ld   = 1'b1;
                        w_pc_nxt   = w_pc_plus4;
                        w_nstate   = S_HOLD;
                    end else if (!stall) begin
                        w_clr_valid = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_ld_hold = 1'b1;
                        w_nstate  = S_FETCH;
                    end
                end
                default: begin
                    w_nstate = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_pc     <= 32'd0;
            r_if_pc4    <= 32'd0;
            r_if_instr  <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_buf_instr <= 32'd0;
        end else begin
            r_state <= w_nstate;
            r_pc    <= w_pc_nxt;
            if (w_clr_valid) begin
                r_if_valid <= 1'b0;
            end else if (w_ld_fetch) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_pc4   <= w_pc_plus4;
                r_if_instr <= imem_rdata;
            end else if (w_ld_hold) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_buf_pc;
                r_if_pc4   <= w_buf_pc_plus4;
                r_if_instr <= r_buf_instr;
            end
            if (w_buf_ld) begin
                r_buf_pc    <= r_pc;
                r_buf_instr <= imem_rdata;
            end
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_wait_cnt  <= 32'd0;
        end else begin
            if (w_ld_fetch || w_ld_hold) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_state == S_FETCH && !imem_ack) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign wait_count  = r_wait_cnt;
`endif

    assign imem_req          = (r_state == S_FETCH);
    assign imem_addr         = r_pc;
    assign current_pc        = r_pc;
    assign if_id_valid       = r_if_valid;
    assign if_id_pc          = r_if_pc;
    assign if_id_pc_plus4    = r_if_pc4;
    assign if_id_instr       = r_if_instr;
    assign if_id_instr_index = r_if_instr[25:0];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage.
// Memory returns either a fixed word or 0xC000_0000 ^ address.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] current_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic [25:0] if_id_instr_index;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    logic        fixed_en;
    logic [31:0] fixed_val;
    int          n_tests;
    int          n_fail;

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ack         (imem_ack),
        .current_pc       (current_pc),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instr      (if_id_instr),
        .if_id_instr_index(if_id_instr_index)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .fetch_count      (fetch_count),
        .wait_count       (wait_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 32'hC000_0000 ^ imem_addr;
        if (fixed_en) imem_rdata = fixed_val;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (current_pc !== 32'h0 || if_id_valid !== 1'b0 ||
            imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl pc=%h v=%b req=%b want 0/0/0",
                     current_pc, if_id_valid, imem_req);
        end
        n_tests++;
        if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0 ||
            if_id_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ifid pc=%h p4=%h i=%h want 0",
                     if_id_pc, if_id_pc_plus4, if_id_instr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++;
        if (imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bubble req=%b v=%b want 1/0",
                     imem_req, if_id_valid);
        end
        tick();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 ||
            if_id_pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL first_fetch v=%b pc=%h p4=%h want 1/0/4",
                     if_id_valid, if_id_pc, if_id_pc_plus4);
        end
        n_tests++;
        if (if_id_instr_index !== 26'h0001234 ||
            current_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL first_idx idx=%h pc=%h want 0001234/4",
                     if_id_instr_index, current_pc);
        end
        tick();
        n_tests++;
        if (current_pc !== 32'h8 || if_id_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL seq8 pc=%h ifpc=%h want 8/4",
                     current_pc, if_id_pc);
        end
        tick();
        n_tests++;
        if (current_pc !== 32'hC || if_id_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL seqC pc=%h ifpc=%h want C/8",
                     current_pc, if_id_pc);
        end
    endtask

    task automatic test_wait();
        fixed_en = 1'b0;
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (if_id_valid !== 1'b0 || current_pc !== 32'hC ||
                imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL wait%0d v=%b pc=%h req=%b want 0/C/1",
                         i, if_id_valid, current_pc, imem_req);
            end
        end
`ifdef IF_FETCH_PERF_CNT_EN
        n_tests++;
        if (wait_count !== 32'd3 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_wait w=%0d f=%0d want 3/3",
                     wait_count, fetch_count);
        end
`endif
        imem_ack = 1'b1;
        tick();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC ||
            if_id_instr !== 32'hC000_000C ||
            current_pc !== 32'h10) begin
            n_fail++;
            $display("FAIL wait_done v=%b pc=%h i=%h cur=%h",
                     if_id_valid, if_id_pc, if_id_instr, current_pc);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick();
        n_tests++;
        if (imem_req !== 1'b0 || if_id_pc !== 32'hC ||
            if_id_instr !== 32'hC000_000C || if_id_valid !== 1'b1 ||
            current_pc !== 32'h14) begin
            n_fail++;
            $display("FAIL hold_enter req=%b pc=%h i=%h cur=%h",
                     imem_req, if_id_pc, if_id_instr, current_pc);
        end
        tick();
        n_tests++;
        if (imem_req !== 1'b0 || if_id_pc !== 32'hC ||
            current_pc !== 32'h14) begin
            n_fail++;
            $display("FAIL hold_stay req=%b pc=%h cur=%h",
                     imem_req, if_id_pc, current_pc);
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 ||
            if_id_pc_plus4 !== 32'h14 ||
            if_id_instr !== 32'hC000_0010) begin
            n_fail++;
            $display("FAIL hold_drain v=%b pc=%h p4=%h i=%h",
                     if_id_valid, if_id_pc, if_id_pc_plus4,
                     if_id_instr);
        end
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL hold_next req=%b addr=%h want 1/14",
                     imem_req, imem_addr);
        end
        tick();
        n_tests++;
        if (if_id_pc !== 32'h14 || current_pc !== 32'h18) begin
            n_fail++;
            $display("FAIL after_hold pc=%h cur=%h want 14/18",
                     if_id_pc, current_pc);
        end
`ifdef IF_FETCH_PERF_CNT_EN
        n_tests++;
        if (fetch_count !== 32'd6) begin
            n_fail++;
            $display("FAIL perf_fetch f=%0d want 6", fetch_count);
        end
`endif
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0004_8D03;
        stall          = 1'b1;
        tick();
        n_tests++;
        if (current_pc !== 32'h0004_8D00 || if_id_valid !== 1'b0 ||
            imem_req !== 1'b1 || if_id_pc !== 32'h14) begin
            n_fail++;
            $display("FAIL redirect cur=%h v=%b req=%b pc=%h",
                     current_pc, if_id_valid, imem_req, if_id_pc);
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        tick();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0004_8D00 ||
            if_id_instr !== 32'hC004_8D00 ||
            current_pc !== 32'h0004_8D04) begin
            n_fail++;
            $display("FAIL redir_fetch v=%b pc=%h i=%h cur=%h",
                     if_id_valid, if_id_pc, if_id_instr, current_pc);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (current_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_set cur=%h want fffffffc", current_pc);
        end
        tick();
        n_tests++;
        if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 ||
            current_pc !== 32'h0 ||
            if_id_instr !== 32'h3FFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap pc=%h p4=%h cur=%h i=%h",
                     if_id_pc, if_id_pc_plus4, current_pc,
                     if_id_instr);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        tick();
        n_tests++;
        if (imem_req !== 1'b0 || current_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL pre_rst req=%b cur=%h want 0/4",
                     imem_req, current_pc);
        end
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (current_pc !== 32'h0 || if_id_valid !== 1'b0 ||
            imem_req !== 1'b0 || if_id_pc !== 32'h0 ||
            if_id_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst cur=%h v=%b req=%b pc=%h i=%h",
                     current_pc, if_id_valid, imem_req, if_id_pc,
                     if_id_instr);
        end
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_refetch req=%b addr=%h want 1/0",
                     imem_req, imem_addr);
        end
        tick();
        n_tests++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 ||
            if_id_instr !== 32'hC000_0000) begin
            n_fail++;
            $display("FAIL rst_first v=%b pc=%h i=%h",
                     if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b1;
        fixed_en       = 1'b1;
        fixed_val      = 32'h0800_1234;
        test_reset();
        test_wait();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
